// File: rtl/mips_defs.sv
// mips_defs: fetch state encoding, address map and exception codes shared across the core.
package mips_defs;
  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FAULT = 2'd2} fetch_state_e;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] IM_BASE = 32'h0000_3000;
  localparam logic [31:0] IM_LAST = 32'h0000_4FFC;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  function automatic logic is_legal(input logic [31:0] a);
    return a[1:0] == 2'b00 && a >= IM_BASE && a <= IM_LAST;
  endfunction
endpackage

// File: rtl/fetch_ctrl_npc_sel.sv
// npc_sel: priority mux choosing the next fetch address.
module npc_sel
  import mips_defs::*;
(
  input  fetch_state_e state,
  input  logic         legal,
  input  logic         stall,
  input  logic         br_taken,
  input  logic         exc_req,
  input  logic         eret,
  input  logic [31:0]  pc,
  input  logic [31:0]  br_target,
  input  logic [31:0]  epc,
  output logic [31:0]  npc
);
  logic hold;
  always_comb begin
    hold = state != RUN || !legal || stall;
    npc = exc_req ? HANDLER_PC :
          (eret && state != BOOT) ? epc :
          hold ? pc :
          br_taken ? br_target : pc + 32'd4;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: IF-stage PC sequencer with redirect, exception entry, eret and AdEL fault parking.
module fetch_ctrl
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic        if_valid,
  output logic        if_adel,
  output logic [31:0] fetch_cnt
);
  fetch_state_e state, state_n;
  logic legal, cnt_en;
  logic [31:0] npc;
  npc_sel u_npc_sel (
    .state(state), .legal(legal), .stall(stall), .br_taken(br_taken),
    .exc_req(exc_req), .eret(eret), .pc(pc), .br_target(br_target),
    .epc(epc), .npc(npc)
  );
  always_comb begin
    legal = is_legal(pc);
    state_n = (exc_req || state == BOOT || eret) ? RUN :
              (state == RUN && !legal) ? FAULT : state;
    cnt_en = state == RUN && legal && !stall && !exc_req && !eret;
    if_valid = reset && state == RUN && legal;
    if_adel = reset && (state == FAULT || (state == RUN && !legal));
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_PC;
      state <= BOOT;
      fetch_cnt <= '0;
    end else begin
      pc <= npc;
      state <= state_n;
      if (cnt_en) fetch_cnt <= fetch_cnt + 32'd1;
    end
  end
endmodule
